// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: control FSM states
// and the default operand width.
package serial_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b - bin), LSB first, with an
// internal start/busy/done sequencer. Optional signed overflow: BSS_OVERFLOW_EN.
module bit_serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef BSS_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sipo;
    logic [WIDTH-1:0] sipo_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             cell_d;
    logic             cell_bo;

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bo)
    );

    assign sipo_next = {cell_d, sipo[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef BSS_OVERFLOW_EN
    logic a_sign;
    logic b_sign;

    // Sign bits latched at start; ovf registered with the final result bit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
        end else if (last) begin
            ovf <= (a_sign != b_sign) && (cell_d != a_sign);
        end
    end
`endif

    // Datapath: operand shift registers, borrow FF, SIPO and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sipo   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                borrow <= bin;
                cnt    <= '0;
                sipo   <= '0;
                busy   <= 1'b1;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                borrow <= cell_bo;
                sipo   <= sipo_next;
                if (last) begin
                    busy <= 1'b0;
                    diff <= sipo_next;
                    bout <= cell_bo;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed self-checking bench for bit_serial_subtractor (WIDTH=8).
// Overflow checks are compiled in when BSS_OVERFLOW_EN is defined.
module tb_bit_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef BSS_OVERFLOW_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef BSS_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start for one edge with the given operands
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a     = av;
        b     = bv;
        bin   = cv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges until done is seen high (bounded)
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;
    int seen;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_diff", 32'(diff), 0);
        check("rst_bout", 32'(bout), 0);
`ifdef BSS_OVERFLOW_EN
        check("rst_ovf", 32'(ovf), 0);
`endif

        // rst wins over start
        start = 1'b1;
        a     = 8'd3;
        tick();
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // 100 - 37 with latency and single-cycle done pulse
        start_op(8'd100, 8'd37, 1'b0);
        check("t1_busy", 32'(busy), 1);
        check("t1_done_early", 32'(done), 0);
        wait_done(n);
        check("t1_latency", 32'(n), W);
        check("t1_busy_at_done", 32'(busy), 0);
        check("t1_diff", 32'(diff), 63);
        check("t1_bout", 32'(bout), 0);
        tick();
        check("t1_done_pulse", 32'(done), 0);
        check("t1_diff_hold", 32'(diff), 63);

        // 5 - 10
        start_op(8'h05, 8'h0A, 1'b0);
        wait_done(n);
        check("t2_diff", 32'(diff), 'hFB);
        check("t2_bout", 32'(bout), 1);

        // 0 - 0 - 1
        start_op(8'h00, 8'h00, 1'b1);
        wait_done(n);
        check("t3_diff", 32'(diff), 'hFF);
        check("t3_bout", 32'(bout), 1);

        // signed overflow boundary
        start_op(8'h80, 8'h01, 1'b0);
        wait_done(n);
        check("t4_diff", 32'(diff), 'h7F);
        check("t4_bout", 32'(bout), 0);
`ifdef BSS_OVERFLOW_EN
        check("t4_ovf", 32'(ovf), 1);
`endif
        start_op(8'h10, 8'h01, 1'b0);
        wait_done(n);
        check("t5_diff", 32'(diff), 'h0F);
`ifdef BSS_OVERFLOW_EN
        check("t5_ovf", 32'(ovf), 0);
`endif
        tick();

        // reset at the 4th shift edge aborts the operation
        start_op(8'hF0, 8'h0F, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_diff", 32'(diff), 0);
        check("abort_done", 32'(done), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        check("abort_no_done", 32'(seen), 0);

        // start during SHIFT is ignored
        start_op(8'd50, 8'd20, 1'b0);
        tick();
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("ign_latency", 32'(n), W - 2);
        check("ign_diff", 32'(diff), 30);
        tick();

        // back-to-back: restart accepted in the done cycle
        start_op(8'd100, 8'd37, 1'b0);
        wait_done(n);
        check("b2b_first_diff", 32'(diff), 63);
        a     = 8'h01;
        b     = 8'h02;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_diff_held", 32'(diff), 63);
        wait_done(n);
        check("b2b_gap", 32'(n + 1), W + 1);
        check("b2b_diff", 32'(diff), 'hFF);
        check("b2b_bout", 32'(bout), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
